idct: RTL and testbench
=======================

IDCT -- requirements
Module: idct

Interface
REQ-001 Parameter IN_W, default 12: width of each signed two's-complement input coefficient.
REQ-002 Parameter OUT_W, default 8: width of each unsigned output sample.
REQ-003 Parameter FRAC, default 13: fractional bits of the cosine constants; FRAC SHALL be at least 13.
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port in_valid, input, 1: high when in_x holds a coefficient vector.
REQ-007 Port in_ready, output, 1: high when the block accepts in_x this cycle.
REQ-008 Port in_x, input, 8 x IN_W: coefficients X[0..7], orthonormal DCT-II scaling, signed.
REQ-009 Port out_valid, output, 1: high when out_y holds a result.
REQ-010 Port out_ready, input, 1: downstream accepts out_y this cycle.
REQ-011 Port out_y, output, 8 x OUT_W: reconstructed samples y[0..7], unsigned.
REQ-012 Port out_clip, output, 8: bit n is high when y[n] was clamped.

Function
REQ-013 The block SHALL compute the 8-point 1-D inverse DCT: y[n] = sum over k of a_k * X[k] * cos((2n+1)k*pi/16), with a_0 = sqrt(1/8) and a_k = 1/2 for k >= 1.
REQ-014 The datapath SHALL be Loeffler-style butterflies and rotations in 4 register stages, the inverse of the team's forward DCT flow graph.
REQ-015 Every output SHALL be within +/-1 LSB of the real-valued result rounded half away from zero, then clamped to 0..255.
REQ-016 Internal widths SHALL be sized so no intermediate overflows for any IN_W-bit input.
REQ-017 Clamp: a result below 0 SHALL output 0, a result above 255 SHALL output 255, and in both cases the corresponding out_clip bit SHALL be 1.
REQ-018 A transfer SHALL occur on each edge where both valid and ready are high, on either port.
REQ-019 Global enable en = (!out_valid) || out_ready; in_ready SHALL equal en combinationally.
REQ-020 When en=1, all 4 stages and their valid bits SHALL advance one position; when en=0, all stage registers SHALL hold.
REQ-021 Latency: a vector accepted on edge t SHALL appear on out_y with out_valid=1 after edge t+4, given en=1 throughout.
REQ-022 Throughput SHALL be one vector per cycle with no stalls.
REQ-023 Order SHALL be preserved, with no vector lost or duplicated.
REQ-024 Cycles with in_valid=0 SHALL propagate as bubbles with a valid bit of 0.
REQ-025 While out_valid=1 and out_ready=0, out_y and out_clip SHALL remain stable.
REQ-026 out_y and out_clip SHALL be registered outputs.
REQ-027 Data from in_x SHALL be ignored when in_valid=0 or in_ready=0.
REQ-028 Simultaneous output pop and input push in the same cycle SHALL both complete.

Reset
REQ-029 On reset=1 at an edge, all stage valid bits, out_valid, out_y and out_clip SHALL become 0.
REQ-030 While reset is high, in_x SHALL not be captured.
REQ-031 Reset asserted mid-operation SHALL discard every in-flight vector; none SHALL emerge afterwards.
REQ-032 in_ready SHALL read 1 on the cycle after reset deasserts, because out_valid=0.

Verification
REQ-033 Zero vector, out_ready=1 -> 4 cycles later out_valid=1, out_y all 0, out_clip=0x00.
REQ-034 X0=362, X1=100, others 0 -> out_y = 177,170,156,138,118,100,86,79, each +/-1; out_clip=0x00.
REQ-035 Two vectors: X0=1024 -> all y=255 with out_clip=0xFF; X0=-100 -> all y=0 with out_clip=0xFF.
REQ-036 8 back-to-back vectors with out_ready=1 -> out_valid high for 8 consecutive cycles starting 4 cycles after the first accept, results in input order.
REQ-037 5 vectors in flight, out_ready=0 for 6 cycles -> in_ready=0 and out_y stable throughout; after release, all 5 emerge in order with no gaps or duplicates.
REQ-038 Reset for 1 cycle with 3 vectors in flight -> out_valid=0 from the next cycle and none of the 3 ever appear; a new vector accepted afterwards emerges with 4-cycle latency.

Source files
------------

// File: rtl/idct_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : idct_if                                                      |
// | Description : Stream interface of the 8-point inverse DCT. Carries one     |
// |               coefficient vector per transfer on the input side and one     |
// |               sample vector plus per-sample clamp flags on the output side. |
// |               Ports:                                                       |
// |                 in_valid / in_ready  - input handshake                     |
// |                 in_x      [8*IN_W]   - X[k] at bits [k*IN_W +: IN_W]        |
// |                 out_valid / out_ready - output handshake                   |
// |                 out_y     [8*OUT_W]  - y[n] at bits [n*OUT_W +: OUT_W]      |
// |                 out_clip  [8]        - bit n set when y[n] was clamped     |
// |               master: producer/consumer side, slave: the IDCT block.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface idct_if #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [8*IN_W-1:0]    in_x;
    logic                 out_valid;
    logic                 out_ready;
    logic [8*OUT_W-1:0]   out_y;
    logic [7:0]           out_clip;

    modport master (
        output in_valid, in_x, out_ready,
        input  in_ready, out_valid, out_y, out_clip
    );

    modport slave (
        input  in_valid, in_x, out_ready,
        output in_ready, out_valid, out_y, out_clip
    );
endinterface
`default_nettype wire

// File: rtl/idct.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : idct                                                         |
// | Description : 8-point 1-D inverse DCT (orthonormal DCT-II scaling).        |
// |               Even half: X0/X4 butterfly, X2/X6 rotation, butterflies.     |
// |               Odd half : constant rotations of X1/X3/X5/X7, then the final |
// |               output butterfly y[n] = E[n] + O[n], y[7-n] = E[n] - O[n].   |
// |               Four compute stages plus a registered, clamped output.       |
// |               A single enable (out_valid low or out_ready high) advances   |
// |               or freezes the whole pipeline; in_ready equals that enable.  |
// |               Ports: clk, reset (sync, active high), bus (idct_if.slave).  |
// |               FRAC (cosine fraction bits) must be at least 13.             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module idct #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 8,
    parameter int FRAC  = 13
) (
    input  logic  clk,
    input  logic  reset,
    idct_if.slave bus
);

    // Headroom: |y| * 2^FRAC stays below 4 * 2^(IN_W-1) * 2^FRAC for any input.
    localparam int ACC_W = IN_W + FRAC + 4;

    // Cosine constants are tabulated with 24 fraction bits and rounded to FRAC.
    function automatic longint rc(input longint v24);
        int sh;
        sh = 24 - FRAC;
        if (sh <= 0) rc = v24 <<< (-sh);
        else         rc = (v24 + (longint'(1) <<< (sh - 1))) >>> sh;
    endfunction

    localparam logic signed [ACC_W-1:0] c_a0   = ACC_W'(rc(64'sd5931642)); // sqrt(1/8)
    localparam logic signed [ACC_W-1:0] c_c1   = ACC_W'(rc(64'sd8227423)); // cos(1pi/16)/2
    localparam logic signed [ACC_W-1:0] c_c2   = ACC_W'(rc(64'sd7750063)); // cos(2pi/16)/2
    localparam logic signed [ACC_W-1:0] c_c3   = ACC_W'(rc(64'sd6974873)); // cos(3pi/16)/2
    localparam logic signed [ACC_W-1:0] c_c5   = ACC_W'(rc(64'sd4660461)); // cos(5pi/16)/2
    localparam logic signed [ACC_W-1:0] c_c6   = ACC_W'(rc(64'sd3210181)); // cos(6pi/16)/2
    localparam logic signed [ACC_W-1:0] c_c7   = ACC_W'(rc(64'sd1636536)); // cos(7pi/16)/2
    localparam logic signed [ACC_W-1:0] c_half = ACC_W'(longint'(1) <<< (FRAC - 1));
    localparam logic signed [ACC_W-1:0] c_one  = ACC_W'(64'sd1);
    localparam logic signed [ACC_W-1:0] c_ymax = ACC_W'((longint'(1) <<< OUT_W) - 64'sd1);

    function automatic logic signed [ACC_W-1:0] ext(input logic signed [IN_W-1:0] v);
        return ACC_W'(v);
    endfunction

    // Round half away from zero: negative values take half minus one ulp
    // before the floor-shift so that -x.5 lands on -(x+1).
    function automatic logic signed [ACC_W-1:0] round_q(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] b;
        b = v[ACC_W-1] ? (v + c_half - c_one) : (v + c_half);
        return b >>> FRAC;
    endfunction

    logic signed [IN_W-1:0]  w_x [8];
    logic                    w_en;
    logic [8*OUT_W-1:0]      w_y;
    logic [7:0]              w_clip;

    logic                    r1_v, r2_v, r3_v, r4_v;
    logic signed [ACC_W-1:0] r1_a [8];   // [0]=X0+X4, [4]=X0-X4, others pass through
    logic signed [ACC_W-1:0] r2_t [4];   // even-half products t0..t3
    logic signed [ACC_W-1:0] r2_o [4];   // odd-half rotated sums O0..O3
    logic signed [ACC_W-1:0] r3_e [4];   // even-half results E0..E3
    logic signed [ACC_W-1:0] r3_o [4];
    logic signed [ACC_W-1:0] r4_r [8];   // rounded integer samples before clamping
    logic                    r_out_valid;
    logic [8*OUT_W-1:0]      r_out_y;
    logic [7:0]              r_out_clip;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_unpack
            assign w_x[gi] = bus.in_x[gi*IN_W +: IN_W];
        end
    endgenerate

    assign w_en          = !r_out_valid || bus.out_ready;
    assign bus.in_ready  = w_en;
    assign bus.out_valid = r_out_valid;
    assign bus.out_y     = r_out_y;
    assign bus.out_clip  = r_out_clip;

    always_comb begin
        w_y    = '0;
        w_clip = '0;
        for (int n = 0; n < 8; n++) begin
            if (r4_r[n][ACC_W-1]) begin
                w_clip[n] = 1'b1;
            end else if (r4_r[n] > c_ymax) begin
                w_y[n*OUT_W +: OUT_W] = '1;
                w_clip[n]             = 1'b1;
            end else begin
                w_y[n*OUT_W +: OUT_W] = r4_r[n][OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r1_v        <= 1'b0;
            r2_v        <= 1'b0;
            r3_v        <= 1'b0;
            r4_v        <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
            r_out_clip  <= '0;
        end else if (w_en) begin
            // Stage 1: capture and the X0/X4 butterfly.
            r1_v <= bus.in_valid;
            if (bus.in_valid) begin
                r1_a[0] <= ext(w_x[0]) + ext(w_x[4]);
                r1_a[4] <= ext(w_x[0]) - ext(w_x[4]);
                r1_a[1] <= ext(w_x[1]);
                r1_a[2] <= ext(w_x[2]);
                r1_a[3] <= ext(w_x[3]);
                r1_a[5] <= ext(w_x[5]);
                r1_a[6] <= ext(w_x[6]);
                r1_a[7] <= ext(w_x[7]);
            end

            // Stage 2: DC scaling, X2/X6 rotation and odd-half rotations.
            r2_v    <= r1_v;
            r2_t[0] <= c_a0 * r1_a[0];
            r2_t[1] <= c_a0 * r1_a[4];
            r2_t[2] <= c_c2 * r1_a[2] + c_c6 * r1_a[6];
            r2_t[3] <= c_c6 * r1_a[2] - c_c2 * r1_a[6];
            r2_o[0] <= c_c1 * r1_a[1] + c_c3 * r1_a[3] + c_c5 * r1_a[5] + c_c7 * r1_a[7];
            r2_o[1] <= c_c3 * r1_a[1] - c_c7 * r1_a[3] - c_c1 * r1_a[5] - c_c5 * r1_a[7];
            r2_o[2] <= c_c5 * r1_a[1] - c_c1 * r1_a[3] + c_c7 * r1_a[5] + c_c3 * r1_a[7];
            r2_o[3] <= c_c7 * r1_a[1] - c_c5 * r1_a[3] + c_c3 * r1_a[5] - c_c1 * r1_a[7];

            // Stage 3: even-half butterflies.
            r3_v    <= r2_v;
            r3_e[0] <= r2_t[0] + r2_t[2];
            r3_e[1] <= r2_t[1] + r2_t[3];
            r3_e[2] <= r2_t[1] - r2_t[3];
            r3_e[3] <= r2_t[0] - r2_t[2];
            r3_o    <= r2_o;

            // Stage 4: output butterfly and rounding.
            r4_v <= r3_v;
            for (int n = 0; n < 4; n++) begin
                r4_r[n]     <= round_q(r3_e[n] + r3_o[n]);
                r4_r[7 - n] <= round_q(r3_e[n] - r3_o[n]);
            end

            // Output register: clamped samples, held unless a new result arrives.
            r_out_valid <= r4_v;
            if (r4_v) begin
                r_out_y    <= w_y;
                r_out_clip <= w_clip;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_idct.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_idct                                                      |
// | Description : Scoreboard bench for idct. Directed vectors with hand-       |
// |               computed samples; a monitor pops expectations whenever an    |
// |               output transfer occurs and checks values, clamp flags and    |
// |               latency. Stall, back-to-back and reset-flush sequences.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_idct;

    localparam int IN_W  = 12;
    localparam int OUT_W = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    idct_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    idct #(.IN_W(IN_W), .OUT_W(OUT_W), .FRAC(13)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Coefficients X[0..7] and expected y[0..7] (tolerance +/-1) and clamp flags.
    int tx [8][8] = '{
        '{   0,   0,   0,   0,   0, 0, 0, 0},
        '{ 362, 100,   0,   0,   0, 0, 0, 0},
        '{1024,   0,   0,   0,   0, 0, 0, 0},
        '{-100,   0,   0,   0,   0, 0, 0, 0},
        '{ 400,   0,   0,   0, 100, 0, 0, 0},
        '{ 400,   0, -80,   0,   0, 0, 0, 0},
        '{ 362, 400,   0,   0,   0, 0, 0, 0},
        '{ 362,   0,   0, -60,   0, 0, 0, 0}
    };
    int ty [8][8] = '{
        '{  0,   0,   0,   0,   0,   0,   0,   0},
        '{177, 170, 156, 138, 118, 100,  86,  79},
        '{255, 255, 255, 255, 255, 255, 255, 255},
        '{  0,   0,   0,   0,   0,   0,   0,   0},
        '{177, 106, 106, 177, 177, 106, 106, 177},
        '{104, 126, 157, 178, 178, 157, 126, 104},
        '{255, 255, 239, 167,  89,  17,   0,   0},
        '{103, 134, 157, 145, 111,  99, 122, 153}
    };
    logic [7:0] tc [8] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hC3, 8'h00};

    typedef struct {
        int idx;
        int acc;
        bit lat;
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_vec(input int idx);
        int a [8];
        bit bad;
        bad = 1'b0;
        for (int n = 0; n < 8; n++) begin
            a[n] = int'(bus.out_y[n*OUT_W +: OUT_W]);
            if (a[n] - ty[idx][n] > 1 || ty[idx][n] - a[n] > 1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL out_y vec%0d: actual=%0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d required=%0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d (+/-1)",
                     idx, a[0], a[1], a[2], a[3], a[4], a[5], a[6], a[7],
                     ty[idx][0], ty[idx][1], ty[idx][2], ty[idx][3],
                     ty[idx][4], ty[idx][5], ty[idx][6], ty[idx][7]);
        end
        chk($sformatf("out_clip vec%0d", idx), 64'(bus.out_clip), 64'(tc[idx]));
    endtask

    // Monitor: every output transfer must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: actual out_y=%h required no output", bus.out_y);
            end else begin
                mon_e = sb.pop_front();
                check_vec(mon_e.idx);
                if (mon_e.lat)
                    chk($sformatf("latency vec%0d", mon_e.idx), 64'(cyc - mon_e.acc), 64'd4);
            end
        end
    end

    // Present vector idx and hold it until an edge accepts it.
    task automatic send(input int idx, input bit push, input bit lat);
        int guard;
        guard = 0;
        for (int k = 0; k < 8; k++) bus.in_x[k*IN_W +: IN_W] = IN_W'(tx[idx][k]);
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready) begin
            guard++;
            if (guard > 200) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout vec%0d: actual in_ready=0 required 1", idx);
                finish_run();
            end
            @(negedge clk);
        end
        if (push) sb.push_back('{idx: idx, acc: cyc + 1, lat: lat});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_x     = {$urandom, $urandom, $urandom};
    endtask

    task automatic wait_empty();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 100) begin
            @(posedge clk);
            g++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual simulation still running required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit         quiet;
        logic [63:0] snap_y;
        logic [7:0]  snap_c;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset out_y",     64'(bus.out_y),     64'd0);
        chk("reset out_clip",  64'(bus.out_clip),  64'd0);
        chk("reset in_ready",  64'(bus.in_ready),  64'd1);
        @(posedge clk);
        #1;

        // Single vectors separated by bubbles.
        for (int i = 0; i < 8; i++) begin
            send(i, 1'b1, 1'b1);
            repeat (2) @(posedge clk);
            #1;
        end
        wait_empty();

        // Back-to-back stream: latency 4 on each implies 8 consecutive outputs.
        for (int i = 0; i < 8; i++) send(7 - i, 1'b1, 1'b1);
        wait_empty();

        // Fill with out_ready low, then hold for six cycles.
        bus.out_ready = 1'b0;
        send(1, 1'b1, 1'b0);
        send(2, 1'b1, 1'b0);
        send(5, 1'b1, 1'b0);
        send(6, 1'b1, 1'b0);
        send(7, 1'b1, 1'b0);
        @(negedge clk);
        snap_y = 64'(bus.out_y);
        snap_c = bus.out_clip;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("stall in_ready",  64'(bus.in_ready),  64'd0);
            chk("stall out_valid", 64'(bus.out_valid), 64'd1);
            chk("stall out_y",     64'(bus.out_y),     snap_y);
            chk("stall out_clip",  64'(bus.out_clip),  64'(snap_c));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("release no_gap", 64'(bus.out_valid), 64'd1);
        end
        @(negedge clk);
        chk("release no_extra", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        wait_empty();

        // Reset with three vectors in flight: none may emerge.
        send(4, 1'b0, 1'b0);
        send(5, 1'b0, 1'b0);
        send(7, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset in_ready", 64'(bus.in_ready), 64'd1);
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid) quiet = 1'b0;
            @(negedge clk);
        end
        chk("flush out_valid stays 0", 64'(!quiet), 64'd0);
        @(posedge clk);
        #1;
        send(1, 1'b1, 1'b1);
        wait_empty();

        finish_run();
    end

endmodule
`default_nettype wire
